// File: rtl/eth_frame_tx.sv
// eth_frame_tx: byte-wide Ethernet frame transmitter.
// Wraps buffer bytes with preamble/SFD, zero pad, CRC-32 FCS and IFG.
module eth_frame_tx #(
   parameter int ADDR_W     = 11,
   parameter int RD_LAT     = 2,
   parameter int MIN_LEN    = 60,
   parameter int IFG_BYTES  = 12,
   parameter bit SEQ_EN     = 1'b0,
   parameter int SEQ_OFFSET = 42
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   frame_len,
   input  logic [7:0]        repeat_count,
   output logic [ADDR_W-1:0] mem_address,
   input  logic [7:0]        mem_q,
   output logic [7:0]        tx_data,
   output logic              tx_en,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       seq
);
   localparam int CW = ADDR_W + 2;
   localparam logic [CW-1:0] ONE   = CW'(1);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_LEN);
   localparam logic [CW-1:0] IFG_C = CW'(IFG_BYTES);
   localparam logic [CW-1:0] SEQ_C = CW'(SEQ_OFFSET);
   localparam logic [CW-1:0] FET_C = CW'(8 - RD_LAT);
   localparam logic [ADDR_W:0] LONE = (ADDR_W+1)'(1);

   typedef enum logic [2:0] {
      IDLE, PRE, SFD, DATA, PAD, FCS, IFG
   } state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   rd_left;
   logic [7:0]        rep_q;
   logic [31:0]       crc;
   logic [31:0]       crc_inv;
   logic [CW-1:0]     len_x;
   logic [CW-1:0]     cnt_inc;
   logic              accept, reject, fetch_go;
   logic              tx_en_d, busy_d, done_d, err_d;
   logic [7:0]        tx_data_d;

   function automatic logic [31:0] crc_byte(
      input logic [31:0] c,
      input logic [7:0]  d
   );
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      return r;
   endfunction

   assign crc_inv = ~crc;
   assign len_x   = {1'b0, len_q};
   assign cnt_inc = cnt + ONE;
   assign accept  = (state == IDLE) && start && (frame_len != '0);
   assign reject  = (state == IDLE) && start && (frame_len == '0);
   assign fetch_go = ((state_n == PRE) && (cnt_n == FET_C))
                   || ((state_n == SFD) && (RD_LAT == 1));

   // state, counters, CRC, sequence number and read-address walker
   always_ff @(posedge clock) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         base_q      <= '0;
         len_q       <= '0;
         rep_q       <= '0;
         crc         <= '1;
         seq         <= '0;
         rd_left     <= '0;
         mem_address <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (accept) begin
            base_q <= base_addr;
            len_q  <= frame_len;
            rep_q  <= repeat_count;
         end else if (state == IFG && state_n == PRE) begin
            rep_q <= rep_q - 8'd1;
         end
         if (state_n == SFD)
            crc <= '1;
         else if (state_n == DATA || state_n == PAD)
            crc <= crc_byte(crc, tx_data_d);
         if (state != IFG && state_n == IFG)
            seq <= seq + 16'd1;
         if (fetch_go) begin
            mem_address <= base_q;
            rd_left     <= len_q - LONE;
         end else if (rd_left != '0) begin
            mem_address <= mem_address + ADDR_W'(1);
            rd_left     <= rd_left - LONE;
         end
      end
   end

   // next state and per-state cycle counter
   always_comb begin
      state_n = state;
      cnt_n   = cnt_inc;
      unique case (state)
         IDLE: begin
            cnt_n = '0;
            if (accept) state_n = PRE;
         end
         PRE: begin
            if (cnt == CW'(6)) begin
               state_n = SFD;
               cnt_n   = '0;
            end
         end
         SFD: begin
            state_n = DATA;
            cnt_n   = '0;
         end
         DATA: begin
            if (cnt_inc == len_x) begin
               if (len_x < MIN_C) begin
                  state_n = PAD;
               end else begin
                  state_n = FCS;
                  cnt_n   = '0;
               end
            end
         end
         PAD: begin
            if (cnt_inc == MIN_C) begin
               state_n = FCS;
               cnt_n   = '0;
            end
         end
         FCS: begin
            if (cnt == CW'(3)) begin
               state_n = IFG;
               cnt_n   = '0;
            end
         end
         IFG: begin
            if (cnt_inc == IFG_C) begin
               state_n = (rep_q != 8'd0) ? PRE : IDLE;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // next output values, decoded from the upcoming state
   always_comb begin
      tx_en_d   = 1'b0;
      tx_data_d = 8'h00;
      busy_d    = (state_n != IDLE);
      done_d    = (state == IFG) && (state_n == IDLE);
      err_d     = reject;
      unique case (state_n)
         PRE: begin
            tx_en_d   = 1'b1;
            tx_data_d = 8'h55;
         end
         SFD: begin
            tx_en_d   = 1'b1;
            tx_data_d = 8'hD5;
         end
         DATA: begin
            tx_en_d   = 1'b1;
            tx_data_d = mem_q;
            if (SEQ_EN && cnt_n == SEQ_C)
               tx_data_d = seq[15:8];
            else if (SEQ_EN && cnt_n == SEQ_C + ONE)
               tx_data_d = seq[7:0];
         end
         PAD: begin
            tx_en_d = 1'b1;
         end
         FCS: begin
            tx_en_d   = 1'b1;
            tx_data_d = crc_inv[{cnt_n[1:0], 3'b000} +: 8];
         end
         default: begin
            tx_en_d = 1'b0;
         end
      endcase
   end

   // registered outputs toward the PHY path
   always_ff @(posedge clock) begin
      if (rst) begin
         tx_en   <= 1'b0;
         tx_data <= 8'h00;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         tx_en   <= tx_en_d;
         tx_data <= tx_data_d;
         busy    <= busy_d;
         done    <= done_d;
         err     <= err_d;
      end
   end

endmodule
